// File: rtl/mips_register_writeback_tracker_pkg.sv
// Shared encodings for the register-control bundle and the pipeline slot
// record used by the writeback tracker. The decode control generator emits
// the same control encodings, so both ends agree on their meaning.
package mips_register_writeback_tracker_pkg;

   // Address width carried by every slot record; the tracker's ADDR_WIDTH
   // parameter must match it.
   localparam int SLOT_ADDR_WIDTH = 5;

   typedef enum logic {
      PORT1_SRC_RS = 1'b0,
      PORT1_SRC_RT = 1'b1
   } port1_addr_source_t;

   typedef enum logic [1:0] {
      WADDR_SRC_RT   = 2'd0,
      WADDR_SRC_RD   = 2'd1,
      WADDR_SRC_R31  = 2'd2,
      WADDR_SRC_RSVD = 2'd3
   } write_addr_source_t;

   typedef enum logic {
      WDATA_SRC_ALU = 1'b0,
      WDATA_SRC_MEM = 1'b1
   } write_data_source_t;

   typedef enum logic [1:0] {
      FWD_REGFILE = 2'd0,
      FWD_MEM_ALU = 2'd1,
      FWD_WB_DATA = 2'd2
   } forward_select_t;

   // Write intent of one in-flight instruction.
   typedef struct packed {
      logic                       valid;
      logic                       we;
      logic [SLOT_ADDR_WIDTH-1:0] addr;
      logic                       from_mem;
   } slot_t;

   // Operand source for one EX read address. A load still in MEM has no data
   // yet, so only ALU results are taken from MEM; MEM beats WB because it is
   // the younger producer. Register $0 is never forwarded.
   function automatic forward_select_t forward_for(
      input slot_t                      mem,
      input slot_t                      wb,
      input logic [SLOT_ADDR_WIDTH-1:0] src
   );
      if (src == '0) begin
         return FWD_REGFILE;
      end
      if (mem.valid && mem.we && !mem.from_mem && (mem.addr == src)) begin
         return FWD_MEM_ALU;
      end
      if (wb.valid && wb.we && (wb.addr == src)) begin
         return FWD_WB_DATA;
      end
      return FWD_REGFILE;
   endfunction

endpackage

// File: rtl/mips_register_writeback_tracker_slot.sv
// One pipeline slot of write intent. A bubble clears the slot, load captures
// the incoming record, otherwise the slot holds.
module mips_register_writeback_tracker_slot
   import mips_register_writeback_tracker_pkg::*;
(
   input  logic  clock,
   input  logic  resetN,
   input  logic  load,
   input  logic  bubble,
   input  slot_t d,
   output slot_t q
);

   // Slot register: bubble has priority over load so a killed instruction
   // can never slip through.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         q <= '0;
      end else if (bubble) begin
         q <= '0;
      end else if (load) begin
         q <= d;
      end
   end

endmodule

// File: rtl/mips_register_writeback_tracker.sv
// Consumer end of the decode register-control bundle: resolves register
// addresses, tracks write intent through EX/MEM/WB, raises load-use stalls,
// selects EX operand forwarding and drives the register-file write port.
// Optional macro MIPS_REGISTER_WRITEBACK_TRACKER_DECODE_BYPASS_EN adds
// decodeBypass1/decodeBypass2 for a read-before-write register file.
module mips_register_writeback_tracker
   import mips_register_writeback_tracker_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = SLOT_ADDR_WIDTH,
   parameter int LINK_REGISTER = 31
) (
   input  logic                  clock,
   input  logic                  resetN,
   input  logic                  idValid,
   input  logic                  flush,
   input  logic [ADDR_WIDTH-1:0] idRs,
   input  logic [ADDR_WIDTH-1:0] idRt,
   input  logic [ADDR_WIDTH-1:0] idRd,
   input  logic                  idPort1AddrSource,
   input  logic [1:0]            idWriteAddrSource,
   input  logic                  idWriteDataSource,
   input  logic                  idWriteEnable,
   input  logic [DATA_WIDTH-1:0] wbAluData,
   input  logic [DATA_WIDTH-1:0] wbMemData,
   output logic [ADDR_WIDTH-1:0] port1Addr,
   output logic [ADDR_WIDTH-1:0] port2Addr,
   output logic                  stall,
   output logic [1:0]            forward1Select,
   output logic [1:0]            forward2Select,
   output logic                  rfWriteEnable,
   output logic [ADDR_WIDTH-1:0] rfWriteAddr,
   output logic [DATA_WIDTH-1:0] rfWriteData
`ifdef MIPS_REGISTER_WRITEBACK_TRACKER_DECODE_BYPASS_EN
   ,
   output logic                  decodeBypass1,
   output logic                  decodeBypass2
`endif
);

   logic [ADDR_WIDTH-1:0] write_addr;
   slot_t                 id_slot;
   slot_t                 ex_slot;
   slot_t                 mem_slot;
   slot_t                 wb_slot;
   logic [ADDR_WIDTH-1:0] ex_src1;
   logic [ADDR_WIDTH-1:0] ex_src2;
   logic                  ex_bubble;

   assign port1Addr = (idPort1AddrSource == PORT1_SRC_RT) ? idRt : idRs;
   assign port2Addr = idRt;

   // Destination register chosen by the write-address source; the reserved
   // code behaves like Rt.
   always_comb begin
      write_addr = idRt;
      case (idWriteAddrSource)
         WADDR_SRC_RD:  write_addr = idRd;
         WADDR_SRC_R31: write_addr = ADDR_WIDTH'(LINK_REGISTER);
         default:       write_addr = idRt;
      endcase
   end

   // Record entering EX. Writes to $0 are dropped here so they never reach
   // the register file or the forwarding network.
   always_comb begin
      id_slot          = '0;
      id_slot.valid    = idValid;
      id_slot.we       = idValid & idWriteEnable & (write_addr != '0);
      id_slot.addr     = write_addr;
      id_slot.from_mem = (idWriteDataSource == WDATA_SRC_MEM);
   end

   // A load in EX whose result the ID instruction reads cannot be forwarded
   // in time, so ID waits one cycle behind a bubble.
   assign stall = ex_slot.valid & ex_slot.we & ex_slot.from_mem &
                  ((ex_slot.addr == port1Addr) | (ex_slot.addr == port2Addr)) &
                  idValid;

   // Flush wins over stall; both insert a bubble into EX.
   assign ex_bubble = stall | flush;

   mips_register_writeback_tracker_slot u_ex_slot (
      .clock  (clock),
      .resetN (resetN),
      .load   (1'b1),
      .bubble (ex_bubble),
      .d      (id_slot),
      .q      (ex_slot)
   );

   // Flush also kills the instruction currently in EX before it reaches MEM.
   mips_register_writeback_tracker_slot u_mem_slot (
      .clock  (clock),
      .resetN (resetN),
      .load   (1'b1),
      .bubble (flush),
      .d      (ex_slot),
      .q      (mem_slot)
   );

   mips_register_writeback_tracker_slot u_wb_slot (
      .clock  (clock),
      .resetN (resetN),
      .load   (1'b1),
      .bubble (1'b0),
      .d      (mem_slot),
      .q      (wb_slot)
   );

   // Read addresses of the EX instruction, used only for forwarding; they
   // follow the EX slot through bubbles so a bubble never forwards.
   always_ff @(posedge clock or negedge resetN) begin
      if (!resetN) begin
         ex_src1 <= '0;
         ex_src2 <= '0;
      end else if (ex_bubble) begin
         ex_src1 <= '0;
         ex_src2 <= '0;
      end else begin
         ex_src1 <= port1Addr;
         ex_src2 <= idRt;
      end
   end

   assign forward1Select = forward_for(mem_slot, wb_slot, ex_src1);
   assign forward2Select = forward_for(mem_slot, wb_slot, ex_src2);

   assign rfWriteEnable = wb_slot.valid & wb_slot.we;
   assign rfWriteAddr   = wb_slot.addr;
   assign rfWriteData   = wb_slot.from_mem ? wbMemData : wbAluData;

`ifdef MIPS_REGISTER_WRITEBACK_TRACKER_DECODE_BYPASS_EN
   // ID takes the WB data directly when it reads the register being written
   // this cycle, hiding a read-before-write register file.
   assign decodeBypass1 = rfWriteEnable & (rfWriteAddr == port1Addr);
   assign decodeBypass2 = rfWriteEnable & (rfWriteAddr == port2Addr);
`else
   // Without the bypass the register file must return the value being
   // written in the same cycle.
`endif

endmodule

// File: doc/mips_register_writeback_tracker.md
Name: mips_register_writeback_tracker

Overview:
Consumer end of the register-control bundle that decode produces.
- Resolves port-1, port-2 and write register addresses from the rs/rt/rd fields plus the control bundle.
- Carries each instruction's write intent through EX, MEM and WB slots.
- Detects load-use hazards (stall) and selects operand forwarding for the EX-stage instruction.
- Drives the register-file write port in WB.

Parameters:
DATA_WIDTH, 32, width of register data
ADDR_WIDTH, 5, width of a register address
LINK_REGISTER, 31, address written when the write-address source is R31

Ports:
clock  input  1  rising-edge clock
resetN  input  1  asynchronous active-low reset
idValid  input  1  ID holds a real instruction
flush  input  1  kill the instruction leaving ID and the EX slot
idRs  input  ADDR_WIDTH  rs field
idRt  input  ADDR_WIDTH  rt field
idRd  input  ADDR_WIDTH  rd field
idPort1AddrSource  input  1  0=Rs, 1=Rt
idWriteAddrSource  input  2  0=Rt, 1=Rd, 2=R31, 3 reserved (treated as Rt)
idWriteDataSource  input  1  0=Alu, 1=Memory
idWriteEnable  input  1  instruction writes a register
wbAluData  input  DATA_WIDTH  ALU result in WB
wbMemData  input  DATA_WIDTH  load data in WB
port1Addr  output  ADDR_WIDTH  resolved read address 1 (combinational)
port2Addr  output  ADDR_WIDTH  resolved read address 2, always idRt (combinational)
stall  output  1  hold PC and ID; insert a bubble into EX
forward1Select  output  2  EX operand 1: 0=register file, 1=MEM ALU result, 2=WB data
forward2Select  output  2  same for operand 2
rfWriteEnable  output  1  register-file write strobe
rfWriteAddr  output  ADDR_WIDTH  register-file write address
rfWriteData  output  DATA_WIDTH  register-file write data

Behaviour:
- Slot contents: each of EX, MEM and WB holds {valid, we, addr, fromMem}. EX also holds src1, src2 (resolved read addresses).
- Enqueue rule: slot.we = idValid & idWriteEnable & (addr != 0). Writes to $0 never reach rfWriteEnable and are never forwarded.
- Advance: every cycle WB<=MEM and MEM<=EX. EX<=ID unless stall or flush, in which case EX<=bubble (all fields zero).
- Stall: stall = EX.valid & EX.we & EX.fromMem & ((EX.addr==port1Addr) | (EX.addr==port2Addr)) & idValid. Combinational; lasts exactly one cycle per load-use pair.
- Flush and stall together: flush wins (bubble); stall is still reported.
- Forwarding (operand n): select 1 if MEM.valid & MEM.we & !MEM.fromMem & MEM.addr==EX.srcN. Else select 2 if WB.valid & WB.we & WB.addr==EX.srcN. Else 0. MEM has priority over WB. A src of 0 always gives 0.
- Writeback: rfWriteEnable = WB.valid & WB.we; rfWriteAddr = WB.addr. rfWriteData = wbMemData if WB.fromMem, else wbAluData. All combinational from the WB slot.
- Latency: ID to rfWriteEnable is 3 clocks, or 4 with one stall.
- Reset (resetN low, asynchronous): all slots cleared. stall=0, forward selects=0, rfWriteEnable=0, rfWriteAddr=0. Reset asserted mid-stream drops all in-flight writes; nothing is written after release until a new instruction reaches WB.

Optional Feature:
MIPS_REGISTER_WRITEBACK_TRACKER_DECODE_BYPASS_EN
- With the macro: adds outputs decodeBypass1 and decodeBypass2 (1 bit each). Each is high when rfWriteEnable is high and rfWriteAddr equals port1Addr or port2Addr respectively. ID then takes rfWriteData, which covers a register file that reads before it writes.
- Without the macro: the outputs are absent and the register file must be write-first.

Decomposition:
- Shared package: encodings for Port1AddrSource, WriteAddrSource and WriteDataSource, the forward-select encodings, and the slot record typedef. The decode control generator already uses the same control encodings.
- One sub-module: mips_register_writeback_tracker_slot, a registered slot with async reset, load, bubble and pass-through. Instantiated three times.

Test Plan:
- R-type rd=8 then dependent rs=8 → forward1Select=1 while the consumer is in EX; rfWriteEnable with addr 8 in cycle 3.
- lw rt=9 then add rs=9 → stall=1 for exactly one cycle; the consumer then sees forward1Select=2 with rfWriteData=wbMemData.
- jal (WriteAddrSource=R31) → rfWriteAddr=31 after 3 cycles; addi rt=0 → rfWriteEnable never asserts.
- Same destination in MEM and WB (addr 5) → forward selects 1 (MEM wins); shift-register op with port1AddrSource=Rt → port1Addr=idRt.
- flush with an instruction in EX → it never writes; resetN low with 3 writes in flight → no writes after release; outputs are 0 during reset.
- With the bypass macro: WB writes 12 while ID reads rs=12 → decodeBypass1=1.
